// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO control blocks.
package nco_pkg;

   localparam int unsigned NCO_PW = 16;

   typedef enum logic [1:0] {
      MODE_SINGLE   = 2'd0,
      MODE_WRAP     = 2'd1,
      MODE_TRIANGLE = 2'd2
   } sweep_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      FIN  = 2'd3
   } sweep_state_e;

   // The reserved encoding 3 behaves as a single-shot sweep.
   function automatic sweep_mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_WRAP;
         2'd2:    return MODE_TRIANGLE;
         default: return MODE_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell timer: counts 0..limit while enabled, pulses expire on the terminal count.
module nco_dwell_timer #(
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          en,
   input  logic [DW-1:0] limit,
   output logic          expire
);

   logic [DW-1:0] count;

   assign expire = en && !clear && (count == limit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= (count == limit) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Chirp controller: steps the NCO phase increment from f_start to f_stop in
// single-shot, sawtooth-repeat or triangle fashion.
module nco_sweep_ctrl
   import nco_pkg::*;
#(
   parameter int unsigned PW = NCO_PW,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [1:0]    mode,
   input  logic [PW-1:0] f_start,
   input  logic [PW-1:0] f_stop,
   input  logic [PW-1:0] step,
   input  logic [DW-1:0] dwell,
   output logic [PW-1:0] phase_inc,
   output logic          busy,
   output logic          done,
   output logic          dir_down
);

   sweep_state_e state, state_nxt;
   sweep_mode_e  cfg_mode;
   logic [PW-1:0] cfg_start, cfg_stop, cfg_step;
   logic [DW-1:0] cfg_dwell;

   logic [PW-1:0] phase_nxt;
   logic busy_nxt, done_nxt, dir_nxt;
   logic hold_stop, hold_stop_nxt;
   logic accept, active, expire;
   logic [PW:0] up_sum;
   logic signed [PW:0] dn_diff;

   assign accept  = (state == IDLE) && start && !abort;
   assign active  = (state == UP) || (state == DOWN);
   assign up_sum  = {1'b0, phase_inc} + {1'b0, cfg_step};
   assign dn_diff = $signed({1'b0, phase_inc}) - $signed({1'b0, cfg_step});

   nco_dwell_timer #(.DW(DW)) u_dwell (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (!active),
      .en      (active),
      .limit   (cfg_dwell),
      .expire  (expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         phase_inc <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dir_down  <= 1'b0;
         hold_stop <= 1'b0;
         cfg_mode  <= MODE_SINGLE;
         cfg_start <= '0;
         cfg_stop  <= '0;
         cfg_step  <= '0;
         cfg_dwell <= '0;
      end else begin
         state     <= state_nxt;
         phase_inc <= phase_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         dir_down  <= dir_nxt;
         hold_stop <= hold_stop_nxt;
         if (accept) begin
            cfg_mode  <= decode_mode(mode);
            cfg_start <= f_start;
            cfg_stop  <= f_stop;
            cfg_step  <= step;
            cfg_dwell <= dwell;
         end
      end
   end

   // hold_stop marks that f_stop has been emitted and its dwell period must
   // finish before the mode action; the triangle turn-around applies the first
   // descending step on that same expiry.
   always_comb begin
      state_nxt     = state;
      phase_nxt     = phase_inc;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      dir_nxt       = dir_down;
      hold_stop_nxt = hold_stop;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt     = UP;
               phase_nxt     = f_start;
               busy_nxt      = 1'b1;
               dir_nxt       = 1'b0;
               hold_stop_nxt = 1'b0;
            end
         end
         UP: begin
            if (abort) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               dir_nxt   = 1'b0;
            end else if (expire) begin
               if (hold_stop) begin
                  hold_stop_nxt = 1'b0;
                  case (cfg_mode)
                     MODE_WRAP: phase_nxt = cfg_start;
                     MODE_TRIANGLE: begin
                        if (dn_diff > $signed({1'b0, cfg_start})) begin
                           phase_nxt = dn_diff[PW-1:0];
                           state_nxt = DOWN;
                           dir_nxt   = 1'b1;
                        end else begin
                           phase_nxt = cfg_start;
                        end
                     end
                     default: begin
                        state_nxt = FIN;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                     end
                  endcase
               end else if (up_sum < {1'b0, cfg_stop}) begin
                  phase_nxt = up_sum[PW-1:0];
               end else begin
                  phase_nxt     = cfg_stop;
                  hold_stop_nxt = 1'b1;
               end
            end
         end
         DOWN: begin
            if (abort) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               dir_nxt   = 1'b0;
            end else if (expire) begin
               if (dn_diff > $signed({1'b0, cfg_start})) begin
                  phase_nxt = dn_diff[PW-1:0];
               end else begin
                  phase_nxt = cfg_start;
                  state_nxt = UP;
                  dir_nxt   = 1'b0;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [1:0]  mode;
   logic [15:0] f_start;
   logic [15:0] f_stop;
   logic [15:0] step;
   logic [15:0] dwell;
   logic [15:0] phase_inc;
   logic        busy;
   logic        done;
   logic        dir_down;

   int n_checks = 0;
   int n_pass   = 0;

   nco_sweep_ctrl #(.PW(16), .DW(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .f_start   (f_start),
      .f_stop    (f_stop),
      .step      (step),
      .dwell     (dwell),
      .phase_inc (phase_inc),
      .busy      (busy),
      .done      (done),
      .dir_down  (dir_down)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
   endtask

   task automatic start_sweep(input logic [1:0] m, input logic [15:0] fs,
                              input logic [15:0] fp, input logic [15:0] st,
                              input logic [15:0] dw);
      mode    = m;
      f_start = fs;
      f_stop  = fp;
      step    = st;
      dwell   = dw;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   initial begin
      int exp_single[8];
      int exp_wrap[3];
      int exp_tri[9];
      int exp_dir[9];
      exp_single = '{100, 100, 200, 200, 300, 300, 400, 400};
      exp_wrap   = '{1000, 2500, 3000};
      exp_tri    = '{0, 100, 200, 300, 200, 100, 0, 100, 200};
      exp_dir    = '{0, 0, 0, 0, 1, 1, 0, 0, 0};

      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      mode    = 2'd0;
      f_start = '0;
      f_stop  = '0;
      step    = '0;
      dwell   = '0;
      tick();
      tick();
      chk("rst_phase", phase_inc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dir", dir_down, 0);
      reset_n = 1'b1;
      tick();

      // SINGLE, dwell=1
      start_sweep(2'd0, 100, 400, 100, 1);
      for (int i = 0; i < 8; i++) begin
         chk("single_phase", phase_inc, exp_single[i]);
         chk("single_busy", busy, 1);
         chk("single_done", done, 0);
         tick();
      end
      chk("single_done_pulse", done, 1);
      chk("single_busy_fin", busy, 0);
      chk("single_phase_fin", phase_inc, 400);
      tick();
      chk("single_done_low", done, 0);
      chk("single_phase_hold", phase_inc, 400);

      // WRAP with clamp; start while busy and input changes must be ignored
      start_sweep(2'd1, 1000, 3000, 1500, 0);
      for (int i = 0; i < 9; i++) begin
         chk("wrap_phase", phase_inc, exp_wrap[i % 3]);
         chk("wrap_done", done, 0);
         chk("wrap_busy", busy, 1);
         if (i == 4) begin
            start   = 1'b1;
            mode    = 2'd0;
            f_start = 5;
            f_stop  = 60000;
            step    = 1;
            dwell   = 3;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("wrap_abort_busy", busy, 0);
      chk("wrap_abort_done", done, 0);

      // TRIANGLE, then abort while 200 with simultaneous start
      start_sweep(2'd2, 0, 300, 100, 0);
      for (int i = 0; i < 9; i++) begin
         chk("tri_phase", phase_inc, exp_tri[i]);
         chk("tri_dir", dir_down, exp_dir[i]);
         if (i < 8) tick();
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_phase", phase_inc, 200);
      chk("abort_done", done, 0);
      chk("abort_dir", dir_down, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_ignored", busy, 0);
      chk("abort_start_phase", phase_inc, 200);
      tick();
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_done", done, 0);

      // abort while descending clears dir_down
      start_sweep(2'd2, 0, 300, 100, 0);
      tick();
      tick();
      tick();
      tick();
      chk("tri2_phase", phase_inc, 200);
      chk("tri2_dir", dir_down, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("tri2_abort_dir", dir_down, 0);
      chk("tri2_abort_phase", phase_inc, 200);
      chk("tri2_abort_busy", busy, 0);

      // step near full scale clamps without wrapping
      start_sweep(2'd0, 16, 16'hFFF0, 16'hFFFF, 0);
      chk("big_first", phase_inc, 16);
      tick();
      chk("big_clamp", phase_inc, 16'hFFF0);
      chk("big_busy", busy, 1);
      tick();
      chk("big_done", done, 1);
      chk("big_hold", phase_inc, 16'hFFF0);

      // f_stop below f_start
      tick();
      start_sweep(2'd0, 100, 50, 10, 0);
      chk("inv_first", phase_inc, 100);
      tick();
      chk("inv_stop", phase_inc, 50);
      chk("inv_nodone", done, 0);
      tick();
      chk("inv_done", done, 1);
      chk("inv_hold", phase_inc, 50);

      // reserved mode behaves as SINGLE
      tick();
      start_sweep(2'd3, 100, 200, 100, 0);
      chk("m3_first", phase_inc, 100);
      tick();
      chk("m3_stop", phase_inc, 200);
      tick();
      chk("m3_done", done, 1);
      chk("m3_busy", busy, 0);

      // step=0 holds f_start until abort
      tick();
      start_sweep(2'd0, 100, 400, 0, 0);
      for (int i = 0; i < 1000; i++) begin
         chk("zero_step_phase", phase_inc, 100);
         chk("zero_step_busy", busy, 1);
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("zero_step_abort_busy", busy, 0);
      chk("zero_step_abort_done", done, 0);
      chk("zero_step_abort_phase", phase_inc, 100);

      // asynchronous reset mid-sweep, no resume afterwards
      start_sweep(2'd1, 1000, 3000, 1500, 0);
      tick();
      chk("pre_rst_phase", phase_inc, 2500);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_phase", phase_inc, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_dir", dir_down, 0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_phase", phase_inc, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Frequency-sweep (chirp) controller directly upstream of the NCO core. It drives the NCO's 16-bit user phase-increment input, stepping it from a start value to a stop value at a programmable rate. Supports single-shot, sawtooth-repeat and triangle sweeps, with a start/abort handshake for the control plane.

Parameters:
PW, 16, phase-increment width; must match the NCO phase accumulator width.
DW, 16, dwell counter width.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
abort  in  1  stops an active sweep; takes priority over start.
mode  in  2  sweep mode: 0 SINGLE, 1 WRAP, 2 TRIANGLE, 3 reserved (treated as SINGLE).
f_start  in  PW  first phase increment.
f_stop  in  PW  final phase increment.
step  in  PW  increment added per dwell period.
dwell  in  DW  extra hold cycles per value; each value is held dwell+1 cycles.
phase_inc  out  PW  to NCO phase_inc input.
busy  out  1  high while a sweep is active.
done  out  1  one-cycle pulse when a SINGLE sweep completes.
dir_down  out  1  high while TRIANGLE is descending.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; phase_inc=0, busy=0, done=0, dir_down=0; dwell counter=0.
- Config latch: mode, f_start, f_stop, step and dwell are captured on the accepted start cycle. Later input changes have no effect until the next start.
- States: IDLE, UP, DOWN, FIN.
- IDLE:
  - phase_inc holds its last value.
  - start=1 and abort=0 -> UP. In the next cycle: phase_inc=f_start, busy=1, dwell counter=0.
  - start while busy is ignored.
- Dwell timing:
  - The counter counts 0..dwell. When it equals dwell, the value updates on the next edge and the counter clears.
  - dwell=0 updates the value every cycle.
- UP, at dwell expiry:
  - nxt = phase_inc + step, computed in PW+1 bits (no wrap).
  - If nxt < f_stop: phase_inc=nxt.
  - Otherwise: phase_inc=f_stop, then by mode:
    - SINGLE -> FIN.
    - WRAP -> phase_inc=f_start on the following expiry, stay in UP.
    - TRIANGLE -> DOWN, dir_down=1.
  - f_stop is always emitted for a full dwell period before the mode action.
- DOWN (TRIANGLE only), at dwell expiry:
  - nxt = phase_inc - step, computed in PW+1 bits signed.
  - If nxt > f_start: phase_inc=nxt.
  - Otherwise: phase_inc=f_start, then -> UP with dir_down=0.
- FIN: busy=0, done=1 for exactly one cycle, phase_inc holds f_stop, then -> IDLE.
- Boundary conditions:
  - f_stop <= f_start: phase_inc=f_start for one dwell period, then the UP clamp applies. SINGLE emits f_stop after that.
  - step=0: phase_inc stays at f_start indefinitely; busy=1 until abort.
  - step >= f_stop - f_start: the first expiry clamps straight to f_stop.
  - abort in UP or DOWN: next cycle state=IDLE, busy=0, dir_down=0, no done pulse, phase_inc holds its current value.
  - abort and start in the same cycle while in IDLE: start is ignored.
  - reset_n asserted mid-sweep: immediate return to reset values.
- Latency: start edge to first f_start on phase_inc = 1 cycle. phase_inc is registered, with no combinational path from inputs.

Decomposition:
- Package nco_pkg holds:
  - the sweep_mode_e enum (MODE_SINGLE=0, MODE_WRAP=1, MODE_TRIANGLE=2);
  - the sweep_state_e enum (IDLE, UP, DOWN, FIN);
  - the NCO_PW=16 default width constant.
- One sub-module, nco_dwell_timer: a loadable DW-bit counter with a clear input and an expiry pulse output. It is reused later by the amplitude-envelope block.

Test Plan:
1. Reset: reset_n=0 mid-sweep -> phase_inc=0, busy=0, done=0 asynchronously; the sweep does not resume when reset_n rises.
2. SINGLE: f_start=100, f_stop=400, step=100, dwell=1, start at cycle 0 -> phase_inc 100,100,200,200,300,300,400,400; busy=1 through that sequence; done pulses one cycle after the last 400; phase_inc holds 400.
3. WRAP with clamp: f_start=1000, f_stop=3000, step=1500, dwell=0 -> 1000,2500,3000,1000,2500,3000,… indefinitely; done never asserts.
4. TRIANGLE: f_start=0, f_stop=300, step=100, dwell=0 -> 0,100,200,300,200,100,0,100,…; dir_down=1 exactly while emitting 200,100 on the descent.
5. Abort and ignored start: abort while phase_inc=200 -> busy=0 next cycle, phase_inc stays 200, no done. A start in the same cycle as abort is ignored. A start while busy=1 leaves the sequence unaffected.
6. Edge cases:
   - step=0xFFFF, f_stop=0xFFF0 -> clamps to 0xFFF0 with no wrap.
   - f_stop=50 < f_start=100, SINGLE -> phase_inc 100 then 50, then done.
   - step=0 -> 100 held for 1000 cycles until abort.
